// File: rtl/id_ex_operand_stage.sv
// Operand fetch + ID/EX pipeline register feeding the ALU: 32x32 register file with one
// write-back port, two combinational read ports, stall/flush. Optional macro ID_EX_WB_BYPASS_EN.
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic            ALUSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic            RegWriteD,
  input  logic            ValidD,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] RegData2,
  output logic [XLEN-1:0] ImmExt,
  output logic            ALUSrc,
  output logic [2:0]      ALUControl,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            ValidE
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wb_en;

  // x0 is never written, so it stays at its reset value of zero
  assign wb_en = RegWriteW && (RdW != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[RdW] = ResultW;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  logic            hit1, hit2;
  logic [XLEN-1:0] rs1_val, rs2_val;

`ifdef ID_EX_WB_BYPASS_EN
  assign hit1 = wb_en && (RdW == Rs1D);
  assign hit2 = wb_en && (RdW == Rs2D);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  always_comb begin
    rs1_val = hit1 ? ResultW : regs_q[Rs1D];
    rs2_val = hit2 ? ResultW : regs_q[Rs2D];
    if (Rs1D == 5'd0) rs1_val = '0;
    if (Rs2D == 5'd0) rs2_val = '0;
  end

  logic [XLEN-1:0] src_a_q, src_a_d;
  logic [XLEN-1:0] reg_data2_q, reg_data2_d;
  logic [XLEN-1:0] imm_ext_q, imm_ext_d;
  logic            alu_src_q, alu_src_d;
  logic [2:0]      alu_control_q, alu_control_d;
  logic [4:0]      rd_e_q, rd_e_d;
  logic            reg_write_e_q, reg_write_e_d;
  logic            valid_e_q, valid_e_d;

  // Flush beats stall; a stalled register ignores later write-backs to its sources
  always_comb begin
    src_a_d       = src_a_q;
    reg_data2_d   = reg_data2_q;
    imm_ext_d     = imm_ext_q;
    alu_src_d     = alu_src_q;
    alu_control_d = alu_control_q;
    rd_e_d        = rd_e_q;
    reg_write_e_d = reg_write_e_q;
    valid_e_d     = valid_e_q;
    if (FlushE) begin
      src_a_d       = '0;
      reg_data2_d   = '0;
      imm_ext_d     = '0;
      alu_src_d     = 1'b0;
      alu_control_d = 3'b000;
      rd_e_d        = 5'd0;
      reg_write_e_d = 1'b0;
      valid_e_d     = 1'b0;
    end else if (!StallE) begin
      src_a_d       = rs1_val;
      reg_data2_d   = rs2_val;
      imm_ext_d     = ImmExtD;
      alu_src_d     = ALUSrcD;
      alu_control_d = ALUControlD;
      rd_e_d        = RdD;
      reg_write_e_d = RegWriteD & ValidD;
      valid_e_d     = ValidD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_a_q       <= '0;
      reg_data2_q   <= '0;
      imm_ext_q     <= '0;
      alu_src_q     <= 1'b0;
      alu_control_q <= 3'b000;
      rd_e_q        <= 5'd0;
      reg_write_e_q <= 1'b0;
      valid_e_q     <= 1'b0;
    end else begin
      src_a_q       <= src_a_d;
      reg_data2_q   <= reg_data2_d;
      imm_ext_q     <= imm_ext_d;
      alu_src_q     <= alu_src_d;
      alu_control_q <= alu_control_d;
      rd_e_q        <= rd_e_d;
      reg_write_e_q <= reg_write_e_d;
      valid_e_q     <= valid_e_d;
    end
  end

  assign SrcA       = src_a_q;
  assign RegData2   = reg_data2_q;
  assign ImmExt     = imm_ext_q;
  assign ALUSrc     = alu_src_q;
  assign ALUControl = alu_control_q;
  assign RdE        = rd_e_q;
  assign RegWriteE  = reg_write_e_q;
  assign ValidE     = valid_e_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed vector table, then randomized traffic vs a reference model.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, RdD, RdW, RdE;
  logic [31:0] ImmExtD, ResultW, SrcA, RegData2, ImmExt;
  logic        ALUSrcD, RegWriteD, ValidD, StallE, FlushE, RegWriteW;
  logic [2:0]  ALUControlD, ALUControl;
  logic        ALUSrc, RegWriteE, ValidE;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ImmExtD(ImmExtD),
    .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD), .RegWriteD(RegWriteD), .ValidD(ValidD),
    .StallE(StallE), .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .SrcA(SrcA), .RegData2(RegData2), .ImmExt(ImmExt), .ALUSrc(ALUSrc),
    .ALUControl(ALUControl), .RdE(RdE), .RegWriteE(RegWriteE), .ValidE(ValidE)
  );

  typedef struct packed {
    logic [31:0] a, b, i;
    logic        s;
    logic [2:0]  c;
    logic [4:0]  rd;
    logic        w, v;
  } out_t;

  typedef struct {
    string      nm;
    bit         rst, st, fl, wbe;
    bit [4:0]   rdw;
    bit [31:0]  res;
    bit [4:0]   rs1, rs2, rd;
    bit [31:0]  imm;
    bit         asrc;
    bit [2:0]   ctl;
    bit         rw, vd;
    bit [7:0]   m;
    out_t       e;
  } vec_t;

  localparam bit [7:0] MA = 8'h01, MB = 8'h02, MI = 8'h04, MS = 8'h08,
                       MC = 8'h10, MR = 8'h20, MW = 8'h40, MV = 8'h80, ALL = 8'hFF;
`ifdef ID_EX_WB_BYPASS_EN
  localparam logic [31:0] HAZ = 32'h0000FFFF;
`else
  localparam logic [31:0] HAZ = 32'h00000001;
`endif

  int checks = 0;
  int errors = 0;

  bit [31:0] mregs [32];
  out_t      mexp;

  function automatic out_t o(logic [31:0] a, logic [31:0] b, logic [31:0] i, logic s,
                             logic [2:0] c, logic [4:0] rd, logic w, logic v);
    out_t r;
    r.a = a; r.b = b; r.i = i; r.s = s; r.c = c; r.rd = rd; r.w = w; r.v = v;
    return r;
  endfunction

  function automatic vec_t vi(string nm, bit rst, bit st, bit fl, bit wbe, bit [4:0] rdw,
                              bit [31:0] res, bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd,
                              bit [31:0] imm, bit asrc, bit [2:0] ctl, bit rw, bit vd,
                              bit [7:0] m, out_t e);
    vec_t r;
    r.nm = nm; r.rst = rst; r.st = st; r.fl = fl; r.wbe = wbe; r.rdw = rdw; r.res = res;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.imm = imm; r.asrc = asrc; r.ctl = ctl;
    r.rw = rw; r.vd = vd; r.m = m; r.e = e;
    return r;
  endfunction

  task automatic apply(vec_t v);
    reset = v.rst; StallE = v.st; FlushE = v.fl; RegWriteW = v.wbe; RdW = v.rdw;
    ResultW = v.res; Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd; ImmExtD = v.imm;
    ALUSrcD = v.asrc; ALUControlD = v.ctl; RegWriteD = v.rw; ValidD = v.vd;
  endtask

  // Reference behaviour of one clock edge, straight from the stage's rules
  task automatic model_step(vec_t v);
    bit [31:0] r1, r2;
    bit        wb;
    wb = v.wbe && v.rdw != 0;
    r1 = (v.rs1 == 0) ? 32'd0 : mregs[v.rs1];
    r2 = (v.rs2 == 0) ? 32'd0 : mregs[v.rs2];
`ifdef ID_EX_WB_BYPASS_EN
    if (wb && v.rs1 != 0 && v.rdw == v.rs1) r1 = v.res;
    if (wb && v.rs2 != 0 && v.rdw == v.rs2) r2 = v.res;
`endif
    if (v.rst) begin
      mexp = '0;
      foreach (mregs[k]) mregs[k] = 32'd0;
    end else begin
      if (v.fl) mexp = '0;
      else if (!v.st) mexp = o(r1, r2, v.imm, v.asrc, v.ctl, v.rd, v.rw & v.vd, v.vd);
      if (wb) mregs[v.rdw] = v.res;
    end
  endtask

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_out(string nm, bit [7:0] m, out_t e);
    if (m[0]) cmp({nm, ".SrcA"}, SrcA, e.a);
    if (m[1]) cmp({nm, ".RegData2"}, RegData2, e.b);
    if (m[2]) cmp({nm, ".ImmExt"}, ImmExt, e.i);
    if (m[3]) cmp({nm, ".ALUSrc"}, {31'd0, ALUSrc}, {31'd0, e.s});
    if (m[4]) cmp({nm, ".ALUControl"}, {29'd0, ALUControl}, {29'd0, e.c});
    if (m[5]) cmp({nm, ".RdE"}, {27'd0, RdE}, {27'd0, e.rd});
    if (m[6]) cmp({nm, ".RegWriteE"}, {31'd0, RegWriteE}, {31'd0, e.w});
    if (m[7]) cmp({nm, ".ValidE"}, {31'd0, ValidE}, {31'd0, e.v});
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    out_t z;
    z = '0;
    //                nm          rst st fl wbe rdw res            rs1 rs2 rd imm    as ctl  rw vd  mask   expected
    tbl.push_back(vi("reset",      1, 0, 0, 0, 0, 0,              5,  5,  3, 32'h55, 1, 3'd5, 1, 1, ALL, z));
    tbl.push_back(vi("reset_hold", 1, 0, 0, 0, 0, 0,              5,  5,  3, 32'h55, 1, 3'd5, 1, 1, ALL, z));
    tbl.push_back(vi("wb_x3",      0, 0, 0, 1, 3, 10,             5,  5,  0, 0,      0, 3'd0, 0, 0, MA|MB|MV, z));
    tbl.push_back(vi("wb_x4",      0, 0, 0, 1, 4, 5,              0,  0,  0, 0,      0, 3'd0, 0, 0, 8'h00, z));
    tbl.push_back(vi("rd_34",      0, 0, 0, 0, 0, 0,              3,  4,  9, 0,      0, 3'd0, 1, 1, ALL,
                     o(10, 5, 0, 0, 3'd0, 9, 1, 1)));
    tbl.push_back(vi("x0_wr",      0, 0, 0, 1, 0, 32'hDEADBEEF,   0,  3,  0, 0,      0, 3'd0, 0, 1, MA|MB,
                     o(0, 10, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(vi("x0_rd",      0, 0, 0, 0, 0, 0,              0,  0,  0, 0,      0, 3'd0, 0, 1, MA|MB, z));
    tbl.push_back(vi("ld_imm",     0, 0, 0, 0, 0, 0,              3,  4,  2, 7,      1, 3'd7, 1, 1, ALL,
                     o(10, 5, 7, 1, 3'd7, 2, 1, 1)));
    tbl.push_back(vi("stall1",     0, 1, 0, 1, 3, 20,             4,  3,  6, 99,     0, 3'd1, 0, 0, ALL,
                     o(10, 5, 7, 1, 3'd7, 2, 1, 1)));
    tbl.push_back(vi("stall2",     0, 1, 0, 0, 0, 0,              3,  3,  7, 98,     0, 3'd2, 1, 1, ALL,
                     o(10, 5, 7, 1, 3'd7, 2, 1, 1)));
    tbl.push_back(vi("stall3",     0, 1, 0, 1, 4, 6,              4,  4,  8, 97,     0, 3'd3, 1, 0, ALL,
                     o(10, 5, 7, 1, 3'd7, 2, 1, 1)));
    tbl.push_back(vi("unstall",    0, 0, 0, 0, 0, 0,              3,  4,  1, 1,      0, 3'd2, 1, 1, ALL,
                     o(20, 6, 1, 0, 3'd2, 1, 1, 1)));
    tbl.push_back(vi("flush_stall",0, 1, 1, 0, 0, 0,              3,  4,  1, 1,      1, 3'd3, 1, 1, ALL, z));
    tbl.push_back(vi("valid_q",    0, 0, 0, 0, 0, 0,              3,  3,  5, 3,      1, 3'd3, 1, 0, ALL,
                     o(20, 20, 3, 1, 3'd3, 5, 0, 0)));
    tbl.push_back(vi("x7_init",    0, 0, 0, 1, 7, 1,              0,  0,  0, 0,      0, 3'd0, 0, 0, 8'h00, z));
    tbl.push_back(vi("hazard",     0, 0, 0, 1, 7, 32'h0000FFFF,   7,  7,  0, 0,      0, 3'd0, 0, 1, MA|MB,
                     o(HAZ, HAZ, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(vi("x7_after",   0, 0, 0, 0, 0, 0,              7,  0,  0, 0,      0, 3'd0, 0, 1, MA|MB,
                     o(32'h0000FFFF, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(vi("flush",      0, 0, 1, 0, 0, 0,              7,  7,  4, 9,      1, 3'd6, 1, 1, ALL, z));
    tbl.push_back(vi("undef_ctl",  0, 0, 0, 0, 0, 0,              0,  0,  4, 9,      1, 3'd6, 1, 1, MC|MR|MW,
                     o(0, 0, 0, 0, 3'd6, 4, 1, 0)));
    tbl.push_back(vi("rst_mid",    1, 0, 0, 1, 5, 5,              7,  7,  4, 9,      1, 3'd6, 1, 1, ALL, z));
    tbl.push_back(vi("post_rst",   0, 0, 0, 0, 0, 0,              3,  5,  0, 0,      0, 3'd0, 0, 1, MA|MB|MV,
                     o(0, 0, 0, 0, 0, 0, 0, 1)));

    foreach (mregs[k]) mregs[k] = 32'd0;
    mexp = '0;
    foreach (tbl[n]) begin
      apply(tbl[n]);
      @(posedge clk);
      model_step(tbl[n]);
      #1;
      check_out(tbl[n].nm, tbl[n].m, tbl[n].e);
    end

    for (int n = 0; n < 600; n++) begin
      v.nm   = "rand";
      v.rst  = ($urandom_range(0, 49) == 0);
      v.st   = ($urandom_range(0, 3) == 0);
      v.fl   = ($urandom_range(0, 7) == 0);
      v.wbe  = $urandom_range(0, 1);
      v.rdw  = 5'($urandom_range(0, 7));
      v.res  = $urandom;
      v.rs1  = 5'($urandom_range(0, 7));
      v.rs2  = 5'($urandom_range(0, 7));
      v.rd   = 5'($urandom);
      v.imm  = $urandom;
      v.asrc = $urandom_range(0, 1);
      v.ctl  = 3'($urandom);
      v.rw   = $urandom_range(0, 1);
      v.vd   = $urandom_range(0, 1);
      apply(v);
      @(posedge clk);
      model_step(v);
      #1;
      check_out($sformatf("rand%0d", n), ALL, mexp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
